// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry, derived sizes
// and the almost-empty/almost-full thresholds.
package sync_fifo_pkg;

    localparam int DEF_BUF_WIDTH  = 3;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_DEPTH      = 2 ** DEF_BUF_WIDTH;
    localparam int DEF_CNT_WIDTH  = DEF_BUF_WIDTH + 1;

    localparam int ALMOST_EMPTY_LEVEL = 1;

    // Encoded as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int buf_width);
        return 2 ** buf_width;
    endfunction

    function automatic int almost_full_level(input int buf_width);
        return (2 ** buf_width) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array with a synchronous write port and an
// asynchronous read port; the output register lives in the parent.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_BUF_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Storage is deliberately left unreset so it can map onto RAM resources.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy counter and
// full/empty/almost flags decoded from the registered counter.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int BUF_WIDTH  = DEF_BUF_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [BUF_WIDTH:0]    fifo_counter
);

    localparam int DEPTH = fifo_depth(BUF_WIDTH);
    localparam int CNT_W = BUF_WIDTH + 1;

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(almost_full_level(BUF_WIDTH));
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(ALMOST_EMPTY_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BUF_WIDTH-1:0] PTR_ONE = BUF_WIDTH'(1);

    logic [BUF_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BUF_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  wr_accept;
    logic                  rd_accept;
    fifo_op_e              op;

    // Acceptance uses the pre-edge flags, so a simultaneous request on an
    // empty FIFO only writes and on a full FIFO only reads.
    assign wr_accept = wr_en && !buf_full;
    assign rd_accept = rd_en && !buf_empty;
    assign op        = fifo_op_e'({wr_accept, rd_accept});

    fifo_mem #(
        .ADDR_WIDTH (BUF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (buf_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_data)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        buf_out_d = buf_out_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            buf_out_d = mem_rd_data;
        end

        case (op)
            OP_WRITE: count_d = count_q + CNT_ONE;
            OP_READ:  count_d = count_q - CNT_ONE;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            buf_out_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            buf_out_q <= buf_out_d;
        end
    end

    assign buf_out      = buf_out_q;
    assign fifo_counter = count_q;
    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == FULL_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign almost_full  = (count_q >= AF_LVL);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=8, 8-bit data): a vector table for the
// basic push/pop/fill/drain flow plus hand-written multi-cycle corner cases.
module tb_sync_fifo;

    localparam int BW = 3;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] buf_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] buf_out;
    logic          buf_empty;
    logic          buf_full;
    logic          almost_empty;
    logic          almost_full;
    logic [BW:0]   fifo_counter;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .BUF_WIDTH  (BW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_out;
        logic [BW:0]   exp_cnt;
    } vec_t;

    vec_t vecs[23];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Flags are checked against the occupancy the bench expects.
    task automatic check(input string tag, input logic [DW-1:0] eo, input logic [BW:0] ec);
        cmp({tag, " buf_out"}, 32'(buf_out), 32'(eo));
        cmp({tag, " fifo_counter"}, 32'(fifo_counter), 32'(ec));
        cmp({tag, " buf_empty"}, 32'(buf_empty), 32'(ec == 0));
        cmp({tag, " almost_empty"}, 32'(almost_empty), 32'(ec <= 1));
        cmp({tag, " buf_full"}, 32'(buf_full), 32'(ec == 8));
        cmp({tag, " almost_full"}, 32'(almost_full), 32'(ec >= 7));
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("t=%0t wr=%0b rd=%0b din=%0d -> out=%0d cnt=%0d e=%0b ae=%0b f=%0b af=%0b",
                 $time, w, r, d, buf_out, fifo_counter, buf_empty, almost_empty,
                 buf_full, almost_full);
    endtask

    function automatic vec_t mk(input logic w, input logic r, input int d, input int eo, input int ec);
        vec_t v;
        v.wr      = w;
        v.rd      = r;
        v.din     = DW'(d);
        v.exp_out = DW'(eo);
        v.exp_cnt = (BW+1)'(ec);
        return v;
    endfunction

    initial begin
        // Idle, pop on empty, push 1, push 2 + pop, pop.
        vecs[0]  = mk(0, 0, 0,  0, 0);
        vecs[1]  = mk(0, 1, 0,  0, 0);
        vecs[2]  = mk(1, 0, 1,  0, 1);
        vecs[3]  = mk(1, 1, 2,  1, 1);
        vecs[4]  = mk(0, 1, 0,  2, 0);
        // Fill with 10,2..8, then a dropped push of 9.
        vecs[5]  = mk(1, 0, 10, 2, 1);
        for (int i = 0; i < 7; i++) vecs[6+i] = mk(1, 0, 2+i, 2, 2+i);
        vecs[13] = mk(1, 0, 9,  2, 8);
        // Drain 10,2..8, then a pop on empty.
        vecs[14] = mk(0, 1, 0, 10, 7);
        for (int i = 0; i < 7; i++) vecs[15+i] = mk(0, 1, 0, 2+i, 6-i);
        vecs[22] = mk(0, 1, 0,  8, 0);

        rst    = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        buf_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset", 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cnt);
        end

        // Wrap-around: push 5, pop 5, push 11..16, pop 6.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, DW'(1 + i));
            check($sformatf("wrap_push_a%0d", i), 8, (BW+1)'(i + 1));
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            check($sformatf("wrap_pop_a%0d", i), DW'(1 + i), (BW+1)'(4 - i));
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, DW'(11 + i));
            check($sformatf("wrap_push_b%0d", i), 5, (BW+1)'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0);
            check($sformatf("wrap_pop_b%0d", i), DW'(11 + i), (BW+1)'(5 - i));
        end

        // Simultaneous push+pop while full: only the read happens.
        for (int i = 0; i < 8; i++) step(1, 0, DW'(20 + i));
        check("full_before_both", 16, 8);
        step(1, 1, 99);
        check("both_when_full", 20, 7);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0);
            check($sformatf("drain_after_full%0d", i), DW'(21 + i), (BW+1)'(6 - i));
        end

        // Simultaneous push+pop while empty: only the write happens.
        step(1, 1, 5);
        check("both_when_empty", 27, 1);
        step(0, 1, 0);
        check("pop_after_both_empty", 5, 0);

        // Asynchronous reset between edges with 4 entries stored.
        for (int i = 0; i < 4; i++) step(1, 0, DW'(30 + i));
        step(0, 1, 0);
        step(1, 0, 34);
        check("before_reset", 30, 4);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 7);
        check("post_reset_push", 0, 1);
        step(0, 1, 0);
        check("post_reset_pop", 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised first-in first-out buffer with registered read data.
- Exposes full, empty, almost-full and almost-empty status flags and an occupancy counter.
- Used as a generic elastic buffer between producer and consumer logic in the same clock domain.
- A gate-level netlist synthesised from this RTL must be port-compatible with it.

Parameters:
- BUF_WIDTH, default 3: address width; depth DEPTH = 2**BUF_WIDTH (8 entries by default; 4 gives 16).
- DATA_WIDTH, default 4: width of each stored word.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- buf_in  input  DATA_WIDTH  write data, sampled on a rising edge with wr_en=1.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- buf_out  output  DATA_WIDTH  registered read data.
- buf_empty  output  1  occupancy == 0.
- buf_full  output  1  occupancy == DEPTH.
- almost_empty  output  1  occupancy <= 1.
- almost_full  output  1  occupancy >= DEPTH-1.
- fifo_counter  output  BUF_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: rst=0 acts immediately, independent of clk.
  - wr_ptr=0, rd_ptr=0, fifo_counter=0, buf_out=0.
  - Resulting flags: buf_empty=1, almost_empty=1, buf_full=0, almost_full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents.
- Write: on a rising edge with wr_en=1 and buf_full=0:
  - mem[wr_ptr] <= buf_in; wr_ptr increments.
  - A write while full is ignored with no state change.
- Read: on a rising edge with rd_en=1 and buf_empty=0:
  - buf_out <= mem[rd_ptr]; rd_ptr increments.
  - Data is visible just after that same edge (one-edge latency).
  - A read while empty is ignored and buf_out holds its previous value.
  - buf_out also holds whenever no read occurs.
- Acceptance is decided on the pre-edge flags.
  - Simultaneous wr_en and rd_en while empty: write only, count becomes 1.
  - Simultaneous wr_en and rd_en while full: read only, count becomes DEPTH-1.
  - Otherwise both are performed and the count is unchanged.
- Counter: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- Pointers are BUF_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- All four flags are combinational decodes of fifo_counter. The counter itself is a register, so the flags are glitch-free relative to clk.
- Ordering is strict FIFO; no data loss or duplication across pointer wrap.

Decomposition:
- Shared package holds:
  - default BUF_WIDTH=3 and DATA_WIDTH=4;
  - derived DEPTH and counter width;
  - almost-threshold constants (1 and DEPTH-1).
- One natural sub-module: fifo_mem, a DEPTH x DATA_WIDTH register array with a synchronous write port and a read port. The registered buf_out lives in the top level.
- Pointer, counter and flag logic stay in sync_fifo.

Test Plan:
- Reset then idle:
  - Required outputs: buf_out=0, fifo_counter=0, buf_empty=1, almost_empty=1, buf_full=0, almost_full=0.
  - A pop while empty leaves all outputs unchanged.
- Push 1, then push 2 and pop in the same cycle:
  - Just after the pop edge, buf_out=1.
  - fifo_counter stays 1, almost_empty=1, buf_empty=0.
- Fill from empty with 10,2,3,4,5,6,7,8 (DEPTH=8):
  - After the 7th write: almost_full=1, fifo_counter=7.
  - After the 8th write: buf_full=1, fifo_counter=8.
  - A further push of 9 is dropped and the counter stays 8.
- Drain all 8 entries:
  - buf_out sequence is 10,2,3,4,5,6,7,8.
  - buf_empty=1 after the last read; a 9th pop is ignored and buf_out stays 8.
- Wrap-around:
  - Push 5 words, pop 5, push 6 words (values 11..16), pop 6.
  - Reads must return 11..16 in order with the counter tracking exactly.
- Reset mid-operation:
  - With 4 entries stored, pull rst low between clock edges.
  - All outputs return to reset values immediately.
  - After release, a push of 7 then a pop returns 7.
